mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb_if.sv | 32 +++
 rtl/mem_wb.sv | 114 +++++++++++
 tb/tb_mem_wb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM->WB pipeline register bus: stall/flush control, MEM-stage write requests in, registered WB writes out.
interface mem_wb_if #(
    parameter int N_REG      = 32,
    parameter int N_REG_ADDR = 5
);
    logic [5:0]            i_stall;
    logic                  i_flush;
    logic                  i_mem_wen;
    logic [N_REG_ADDR-1:0] i_mem_waddr;
    logic [N_REG-1:0]      i_mem_wdata;
    logic                  i_mem_whilo;
    logic [N_REG-1:0]      i_mem_hi;
    logic [N_REG-1:0]      i_mem_lo;
    logic                  o_wb_wen;
    logic [N_REG_ADDR-1:0] o_wb_waddr;
    logic [N_REG-1:0]      o_wb_wdata;
    logic                  o_wb_whilo;
    logic [N_REG-1:0]      o_wb_hi;
    logic [N_REG-1:0]      o_wb_lo;

    modport master (
        output i_stall, i_flush, i_mem_wen, i_mem_waddr, i_mem_wdata,
               i_mem_whilo, i_mem_hi, i_mem_lo,
        input  o_wb_wen, o_wb_waddr, o_wb_wdata, o_wb_whilo, o_wb_hi, o_wb_lo
    );

    modport slave (
        input  i_stall, i_flush, i_mem_wen, i_mem_waddr, i_mem_wdata,
               i_mem_whilo, i_mem_hi, i_mem_lo,
        output o_wb_wen, o_wb_waddr, o_wb_wdata, o_wb_whilo, o_wb_hi, o_wb_lo
    );
endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with flush/bubble/hold/pass control.
// Optional retire counter on o_retire_cnt when MEM_WB_RETIRE_CNT_EN is defined.
module mem_wb #(
    parameter int N_REG      = 32,
    parameter int N_REG_ADDR = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mem_wb_if.slave     bus
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0] o_retire_cnt
`endif
);
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [N_REG_ADDR-1:0] NOP_REG_ADDR  = '0;

    typedef struct packed {
        logic                  wen;
        logic [N_REG_ADDR-1:0] waddr;
        logic [N_REG-1:0]      wdata;
        logic                  whilo;
        logic [N_REG-1:0]      hi;
        logic [N_REG-1:0]      lo;
    } wb_t;

    typedef enum logic [1:0] {
        UPD_PASS,
        UPD_HOLD,
        UPD_NOP
    } upd_e;

    localparam wb_t WB_NOP = '{
        wen:   WRITE_DISABLE,
        waddr: NOP_REG_ADDR,
        wdata: '0,
        whilo: 1'b0,
        hi:    '0,
        lo:    '0
    };

    upd_e upd;
    wb_t  wb_d, wb_q;

    // Lower stall bits belong to earlier stages; only MEM (4) and WB (5) matter here.
    logic unused_stall;
    assign unused_stall = ^bus.i_stall[3:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        upd = UPD_PASS;
        if (bus.i_flush) begin
            upd = UPD_NOP;
        end else if (bus.i_stall[4] && !bus.i_stall[5]) begin
            upd = UPD_NOP;
        end else if (bus.i_stall[4]) begin
            upd = UPD_HOLD;
        end
    end

    always_comb begin
        wb_d = wb_q;
        case (upd)
            UPD_NOP:  wb_d = WB_NOP;
            UPD_PASS: wb_d = '{
                wen:   bus.i_mem_wen,
                waddr: bus.i_mem_waddr,
                wdata: bus.i_mem_wdata,
                whilo: bus.i_mem_whilo,
                hi:    bus.i_mem_hi,
                lo:    bus.i_mem_lo
            };
            default:  wb_d = wb_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_q <= WB_NOP;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign bus.o_wb_wen   = wb_q.wen;
    assign bus.o_wb_waddr = wb_q.waddr;
    assign bus.o_wb_wdata = wb_q.wdata;
    assign bus.o_wb_whilo = wb_q.whilo;
    assign bus.o_wb_hi    = wb_q.hi;
    assign bus.o_wb_lo    = wb_q.lo;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_d, retire_cnt_q;

    // Wraps naturally at 2^32.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (upd == UPD_PASS && (bus.i_mem_wen || bus.i_mem_whilo)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign o_retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed table, multi-cycle reset/counter sequences, random vs reference model.
module tb_mem_wb;
    localparam int N_REG      = 32;
    localparam int N_REG_ADDR = 5;

    typedef struct packed {
        logic                  wen;
        logic [N_REG_ADDR-1:0] waddr;
        logic [N_REG-1:0]      wdata;
        logic                  whilo;
        logic [N_REG-1:0]      hi;
        logic [N_REG-1:0]      lo;
    } wb_t;

    typedef struct {
        string     name;
        logic [5:0] stall;
        logic      flush;
        wb_t       in;
        wb_t       exp;
        logic      retire;
    } vec_t;

    localparam wb_t NOP = '0;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    mem_wb_if #(.N_REG(N_REG), .N_REG_ADDR(N_REG_ADDR)) bus ();

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] o_retire_cnt;
`endif

    mem_wb #(.N_REG(N_REG), .N_REG_ADDR(N_REG_ADDR)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .o_retire_cnt (o_retire_cnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    wb_t         exp_q;
    logic [31:0] exp_cnt;
    wb_t         in_q;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic wb_t dut_out();
        return wb_t'({bus.o_wb_wen, bus.o_wb_waddr, bus.o_wb_wdata,
                      bus.o_wb_whilo, bus.o_wb_hi, bus.o_wb_lo});
    endfunction

    task automatic drive(input logic [5:0] s, input logic f, input wb_t w);
        bus.i_stall     = s;
        bus.i_flush     = f;
        bus.i_mem_wen   = w.wen;
        bus.i_mem_waddr = w.waddr;
        bus.i_mem_wdata = w.wdata;
        bus.i_mem_whilo = w.whilo;
        bus.i_mem_hi    = w.hi;
        bus.i_mem_lo    = w.lo;
        in_q            = w;
    endtask

    function automatic wb_t rand_wb();
        wb_t w;
        w.wen   = 1'($urandom_range(0, 1));
        w.waddr = 5'($urandom);
        w.wdata = $urandom;
        w.whilo = 1'($urandom_range(0, 1));
        w.hi    = $urandom;
        w.lo    = $urandom;
        return w;
    endfunction

    // Reference: what the WB stage should show after one edge, given what it showed before.
    function automatic wb_t model_next(input wb_t cur, input logic [5:0] s, input logic f, input wb_t w);
        logic mem_stalled, wb_stalled;
        mem_stalled = s[4];
        wb_stalled  = s[5];
        if (f)                          return NOP;
        if (mem_stalled && !wb_stalled) return NOP;
        if (mem_stalled)                return cur;
        return w;
    endfunction

    function automatic logic model_retire(input logic [5:0] s, input logic f, input wb_t w);
        return !f && !s[4] && (w.wen || w.whilo);
    endfunction

    task automatic check_cnt(input string name);
`ifdef MEM_WB_RETIRE_CNT_EN
        check(name, 128'(o_retire_cnt), 128'(exp_cnt));
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic step(input string name);
        wb_t nxt;
        nxt = model_next(exp_q, bus.i_stall, bus.i_flush, in_q);
        if (model_retire(bus.i_stall, bus.i_flush, in_q)) exp_cnt = exp_cnt + 32'd1;
        @(posedge i_clk);
        #1;
        exp_q = nxt;
        check(name, 128'(dut_out()), 128'(exp_q));
        check_cnt({name, "_cnt"});
    endtask

    function automatic wb_t mk(input logic wen, input logic [4:0] a, input logic [31:0] d,
                               input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        wb_t w;
        w.wen = wen; w.waddr = a; w.wdata = d; w.whilo = whilo; w.hi = hi; w.lo = lo;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_t held;

        // State after the reset-release capture is {wen=1, waddr=5, DEADBEEF}, count 1.
        vecs.push_back('{"bubble",      6'b011111, 1'b0, mk(1, 3, 32'h33, 0, 0, 0),   NOP, 1'b0});
        vecs.push_back('{"hold0",       6'b111111, 1'b0, mk(1, 4, 32'h44, 1, 9, 9),   NOP, 1'b0});
        vecs.push_back('{"hold1",       6'b111111, 1'b0, mk(1, 4, 32'h44, 1, 9, 9),   NOP, 1'b0});
        vecs.push_back('{"hold2",       6'b111111, 1'b0, mk(1, 4, 32'h44, 1, 9, 9),   NOP, 1'b0});
        vecs.push_back('{"flush",       6'b000000, 1'b1, mk(1, 7, 32'h77, 0, 0, 0),   NOP, 1'b0});
        vecs.push_back('{"hilo",        6'b000000, 1'b0, mk(0, 0, 0, 1, 1, 2),        mk(0, 0, 0, 1, 1, 2), 1'b1});
        vecs.push_back('{"wen0_nomask", 6'b000000, 1'b0, mk(0, 9, 32'h123, 0, 0, 0),  mk(0, 9, 32'h123, 0, 0, 0), 1'b0});
        vecs.push_back('{"hold_data",   6'b111111, 1'b0, mk(1, 1, 32'h1, 1, 1, 1),    mk(0, 9, 32'h123, 0, 0, 0), 1'b0});
        vecs.push_back('{"r0_pass",     6'b100000, 1'b0, mk(1, 0, 32'hCAFE, 0, 0, 0), mk(1, 0, 32'hCAFE, 0, 0, 0), 1'b1});
        vecs.push_back('{"flush_stall", 6'b111111, 1'b1, mk(1, 2, 32'h2, 1, 2, 2),    NOP, 1'b0});
        vecs.push_back('{"full_pass",   6'b001111, 1'b0, mk(1, 31, 32'hFFFFFFFF, 1, 32'hAAAA, 32'h5555),
                                                           mk(1, 31, 32'hFFFFFFFF, 1, 32'hAAAA, 32'h5555), 1'b1});
        vecs.push_back('{"bubble2",     6'b010000, 1'b0, mk(1, 6, 32'h6, 1, 6, 6),    NOP, 1'b0});

        // Reset held with random inputs.
        i_rst_n = 1'b0;
        exp_q   = NOP;
        exp_cnt = '0;
        drive(6'($urandom), 1'b0, rand_wb());
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom), 1'($urandom_range(0, 1)), rand_wb());
            @(posedge i_clk);
            #1;
            check($sformatf("reset_nop%0d", i), 128'(dut_out()), 128'(NOP));
            check_cnt($sformatf("reset_cnt%0d", i));
        end

        // Release between edges; the first edge after release captures.
        i_rst_n = 1'b1;
        drive(6'b000000, 1'b0, mk(1, 5, 32'hDEADBEEF, 0, 0, 0));
        step("release_pass");
        check("release_wdata", 128'(bus.o_wb_wdata), 128'(32'hDEADBEEF));

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].in);
            if (vecs[i].retire) exp_cnt = exp_cnt + 32'd1;
            @(posedge i_clk);
            #1;
            exp_q = vecs[i].exp;
            check(vecs[i].name, 128'(dut_out()), 128'(exp_q));
            check_cnt({vecs[i].name, "_cnt"});
        end

        // Async reset in the middle of a hold, between edges.
        drive(6'b000000, 1'b0, mk(1, 12, 32'h1234, 1, 3, 4));
        step("pre_hold_pass");
        drive(6'b111111, 1'b0, rand_wb());
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_q   = NOP;
        exp_cnt = '0;
        check("async_rst_nop", 128'(dut_out()), 128'(NOP));
        check_cnt("async_rst_cnt");
        #2;
        i_rst_n = 1'b1;
        drive(6'b000000, 1'b0, mk(1, 8, 32'h88, 0, 0, 0));
        step("post_async_pass");

        // Held value must survive several hold cycles unchanged.
        held = exp_q;
        drive(6'b111111, 1'b0, rand_wb());
        step("long_hold0");
        step("long_hold1");
        check("long_hold_stable", 128'(dut_out()), 128'(held));

`ifdef MEM_WB_RETIRE_CNT_EN
        // Counter wrap via backdoor preload.
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        exp_cnt = 32'hFFFFFFFF;
        check("cnt_preload", 128'(o_retire_cnt), 128'(exp_cnt));
        drive(6'b000000, 1'b0, mk(0, 1, 32'h1, 1, 5, 6));
        step("cnt_wrap");
        check("cnt_wrap_zero", 128'(o_retire_cnt), 128'(0));
`endif

        // Randomised run against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(6'($urandom), ($urandom_range(0, 7) == 0), rand_wb());
            step($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
